// File: rtl/reg_gpio.sv
// Bus-facing register file for fnc_gpio: output/filter/refclk settings, input readback,
// per-pin rise/fall edge capture with W1C status and a level interrupt.
`timescale 1ns/1ps
module reg_gpio #(
    parameter int N_IN  = 16,
    parameter int N_OUT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [4:0]       addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o,
    output logic             ack_o,
    input  logic [N_IN-1:0]  gpio_in_i,
    output logic [N_OUT-1:0] gpio_out_o,
    output logic [7:0]       dflt_st_o,
    output logic [7:0]       refclk_st_o,
    output logic             irq_o
);

    localparam logic [2:0] A_OUT     = 3'd0;
    localparam logic [2:0] A_IN      = 3'd1;
    localparam logic [2:0] A_DFLT    = 3'd2;
    localparam logic [2:0] A_REFCLK  = 3'd3;
    localparam logic [2:0] A_RISE_EN = 3'd4;
    localparam logic [2:0] A_FALL_EN = 3'd5;
    localparam logic [2:0] A_STAT    = 3'd6;
    localparam logic [2:0] A_OUT_TGL = 3'd7;

    logic             ack_q, ack_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [N_OUT-1:0] out_q, out_d;
    logic [7:0]       dflt_q, dflt_d;
    logic [7:0]       refclk_q, refclk_d;
    logic [N_IN-1:0]  rise_en_q, rise_en_d;
    logic [N_IN-1:0]  fall_en_q, fall_en_d;
    logic [N_IN-1:0]  stat_q, stat_d;
    logic [N_IN-1:0]  gpio_in_q;
    logic             irq_q, irq_d;

    logic             accept;
    logic [2:0]       sel;
    logic [31:0]      rd_mux;
    logic [N_IN-1:0]  stat_set;
    logic [N_IN-1:0]  stat_clr;
    logic             unused_bits;

    assign unused_bits = ^{addr_i[1:0], wdata_i[31:N_IN]};
    assign accept      = req_i & ~ack_q;
    assign sel         = addr_i[4:2];
    assign stat_set    = (gpio_in_i & ~gpio_in_q & rise_en_q) | (~gpio_in_i & gpio_in_q & fall_en_q);

    always_comb begin
        rd_mux = '0;
        case (sel)
            A_OUT:     rd_mux = 32'(out_q);
            A_IN:      rd_mux = 32'(gpio_in_i);
            A_DFLT:    rd_mux = 32'(dflt_q);
            A_REFCLK:  rd_mux = 32'(refclk_q);
            A_RISE_EN: rd_mux = 32'(rise_en_q);
            A_FALL_EN: rd_mux = 32'(fall_en_q);
            A_STAT:    rd_mux = 32'(stat_q);
            default:   rd_mux = '0;
        endcase
    end

    always_comb begin
        out_d     = out_q;
        dflt_d    = dflt_q;
        refclk_d  = refclk_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        stat_clr  = '0;
        if (accept && we_i) begin
            case (sel)
                A_OUT:     out_d     = wdata_i[N_OUT-1:0];
                A_DFLT:    dflt_d    = wdata_i[7:0];
                A_REFCLK:  refclk_d  = wdata_i[7:0];
                A_RISE_EN: rise_en_d = wdata_i[N_IN-1:0];
                A_FALL_EN: fall_en_d = wdata_i[N_IN-1:0];
                A_STAT:    stat_clr  = wdata_i[N_IN-1:0];
                A_OUT_TGL: out_d     = out_q ^ wdata_i[N_OUT-1:0];
                default:   ;
            endcase
        end
        // a new edge event beats a simultaneous W1C on the same bit
        stat_d  = (stat_q & ~stat_clr) | stat_set;
        rdata_d = (accept && !we_i) ? rd_mux : rdata_q;
        ack_d   = accept;
        irq_d   = |stat_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            out_q     <= '0;
            dflt_q    <= 8'h05;
            refclk_q  <= 8'h02;
            rise_en_q <= '0;
            fall_en_q <= '0;
            stat_q    <= '0;
            gpio_in_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            out_q     <= out_d;
            dflt_q    <= dflt_d;
            refclk_q  <= refclk_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            stat_q    <= stat_d;
            gpio_in_q <= gpio_in_i;
            irq_q     <= irq_d;
        end
    end

    assign ack_o       = ack_q;
    assign rdata_o     = rdata_q;
    assign gpio_out_o  = out_q;
    assign dflt_st_o   = dflt_q;
    assign refclk_st_o = refclk_q;
    assign irq_o       = irq_q;

endmodule
